// File: rtl/debouncer_pkg.sv
// Shared types and defaults for the push-button debouncer.
package debouncer_pkg;

    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_RISE_WAIT = 2'd1,
        S_HIGH      = 2'd2,
        S_FALL_WAIT = 2'd3
    } state_t;

    localparam int CNT_MAX_DEF     = 1000000;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/bit_synchronizer.sv
// Plain flop chain for bringing one asynchronous bit into the clk domain.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb sync_d = {sync_q[STAGES-2:0], d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces one raw button into a clean level plus rise/fall pulses.
// Define DEBOUNCER_TOGGLE_EN to add the push-on/push-off btn_toggle output.
module button_debouncer
    import debouncer_pkg::*;
#(
    parameter int CNT_MAX     = CNT_MAX_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise,
`ifdef DEBOUNCER_TOGGLE_EN
    output logic btn_toggle,
`endif
    output logic btn_fall
);

    localparam int             CW       = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CNT_MAX);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    logic          sync_out;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_in),
        .q     (sync_out)
    );

    // Any disagreement in a wait state drops back to the stable state, so
    // a partial count is never carried into the next attempt.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            S_LOW: begin
                if (sync_out) begin
                    state_d = S_RISE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            S_RISE_WAIT: begin
                if (!sync_out) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!sync_out) begin
                    state_d = S_FALL_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            S_FALL_WAIT: begin
                if (sync_out) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign btn_level = level_q;
    assign btn_rise  = rise_q;
    assign btn_fall  = fall_q;

`ifdef DEBOUNCER_TOGGLE_EN
    logic toggle_q, toggle_d;

    // Flips the cycle after each accepted press.
    always_comb toggle_d = toggle_q ^ rise_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) toggle_q <= 1'b0;
        else        toggle_q <= toggle_d;
    end

    assign btn_toggle = toggle_q;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer with CNT_MAX=4, SYNC_STAGES=2.
module tb_button_debouncer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_in = 1'b0;
    logic btn_level, btn_rise, btn_fall;
`ifdef DEBOUNCER_TOGGLE_EN
    logic btn_toggle;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic in;
        logic lvl;
        logic rise;
        logic fall;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    button_debouncer #(.CNT_MAX(4), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
`ifdef DEBOUNCER_TOGGLE_EN
        .btn_toggle(btn_toggle),
`endif
        .btn_fall  (btn_fall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic l, input logic r, input logic f);
        chk({nm, "_level"}, 32'(btn_level), 32'(l));
        chk({nm, "_rise"},  32'(btn_rise),  32'(r));
        chk({nm, "_fall"},  32'(btn_fall),  32'(f));
    endtask

    task automatic add(input logic in, input logic l, input logic r, input logic f, input int n);
        vec_t v;
        v.in = in; v.lvl = l; v.rise = r; v.fall = f;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic do_reset(input logic in_val);
        @(negedge clk);
        rst_n  = 1'b0;
        btn_in = in_val;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Level must appear on the 7th edge after release (first sampling edge + 6).
    task automatic check_rise_after_release(input string nm);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            chk_out($sformatf("%s_e%0d", nm, k), k >= 7, k == 7, 1'b0);
        end
    endtask

    initial begin
        vec_t e;

        // Reset held with button pressed
        rst_n  = 1'b0;
        btn_in = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk_out("rst_hold", 1'b0, 1'b0, 1'b0);
        chk("rst_cnt", 32'(dut.cnt_q), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_rise_after_release("rst_rel");

        // Asynchronous reset in the middle of a count
        do_reset(1'b0);
        @(negedge clk);
        btn_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_cnt", 32'(dut.cnt_q), 32'd2);
        chk("mid_state", 32'(dut.state_q), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("mid_rst", 1'b0, 1'b0, 1'b0);
        chk("mid_rst_cnt", 32'(dut.cnt_q), 32'd0);
        chk("mid_rst_state", 32'(dut.state_q), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_rise_after_release("mid_rel");

        // Table: clean press/release, bounce rejection, glitch then settle, fast toggling
        add(1, 0, 0, 0, 6); add(1, 1, 1, 0, 1); add(1, 1, 0, 0, 5);
        add(0, 1, 0, 0, 6); add(0, 0, 0, 1, 1); add(0, 0, 0, 0, 5);
        for (int i = 0; i < 10; i++) begin
            add(1, 0, 0, 0, 3); add(0, 0, 0, 0, 1);
        end
        add(0, 0, 0, 0, 4);
        add(1, 0, 0, 0, 2); add(0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 6); add(1, 1, 1, 0, 1); add(1, 1, 0, 0, 3);
        add(0, 1, 0, 0, 6); add(0, 0, 0, 1, 1); add(0, 0, 0, 0, 3);
        for (int i = 0; i < 10; i++) begin
            add(1, 0, 0, 0, 1); add(0, 0, 0, 0, 1);
        end
        add(0, 0, 0, 0, 3);

        do_reset(1'b0);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            btn_in = vecs[i].in;
            sb.push_back(vecs[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            chk_out($sformatf("vec%0d", i), e.lvl, e.rise, e.fall);
        end

`ifdef DEBOUNCER_TOGGLE_EN
        do_reset(1'b0);
        for (int p = 1; p <= 3; p++) begin
            @(negedge clk); btn_in = 1'b1;
            repeat (10) @(posedge clk);
            @(negedge clk); btn_in = 1'b0;
            repeat (10) @(posedge clk);
            #1;
            chk($sformatf("toggle_p%0d", p), 32'(btn_toggle), 32'(p % 2));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
